gpu_text_writer: RTL and testbench
==================================

// Module: gpu_text_writer
// PURPOSE
//   Bus initiator that drives the write port of the text-mode VGA GPU (CE/RW/DATA sampled on
//   falling edge of CPU clock). Accepts a byte stream (valid/ready) into a FIFO and emits one
//   GPU write per byte, generating the bus clock and honouring the GPU's post-write and
//   screen-clear busy periods. Lets a UART/soft core print text without 6502 bus timing.
// PARAMETERS
//   FIFO_DEPTH  16    character FIFO entries, power of 2, >= 2
//   CLK_DIV     2     BUS_CLK half-period in CLK_SYS cycles (BUS_CLK = CLK_SYS/(2*CLK_DIV)), >= 1
//   GAP_CYCLES  1     BUS_CLK cycles CE held high after each strobe, >= 1
//   CLEAR_WAIT  4803  BUS_CLK cycles CE held high after a 0x7F (clear) strobe
//   AUTO_CR     1     1: byte 0x0A is emitted as 0x0D then 0x0A
// PORTS
//   CLK_SYS     in   1  system clock; all logic rising-edge
//   RST         in   1  asynchronous, active-high reset
//   CHAR_DATA   in   8  byte to print
//   CHAR_VALID  in   1  CHAR_DATA valid
//   CHAR_READY  out  1  FIFO can accept; push = CHAR_VALID & CHAR_READY
//   BUSY        out  1  FIFO non-empty or FSM not in IDLE
//   BUS_CLK     out  1  generated CPU-side clock to GPU CLK_CPU
//   BUS_CE      out  1  chip enable, active low
//   BUS_RW      out  1  1 = read, 0 = write
//   BUS_DATA    out  8  write data
// BEHAVIOUR
//   Reset (async, while RST=1): BUS_CLK=0, BUS_CE=1, BUS_RW=1, BUS_DATA=0, CHAR_READY=0,
//     BUSY=0, FIFO empty, divider=0, FSM=IDLE, pending-LF cleared. Reset mid-strobe aborts
//     immediately; no partial write completes.
//   Divider: counter 0..CLK_DIV-1; BUS_CLK toggles on wrap. "tick" = CLK_SYS cycle in which
//     BUS_CLK goes 0->1. BUS_CE/BUS_RW/BUS_DATA and FSM change only on tick, so they are
//     stable for CLK_DIV CLK_SYS cycles around every BUS_CLK falling edge.
//   FIFO: CHAR_READY = ~full (registered count), 0 during reset. Push when full is refused
//     even if a pop occurs that cycle. Pop only on tick in IDLE. Order preserved.
//   FSM (evaluated on tick):
//     IDLE:   FIFO empty -> stay. Else pop b. If b==0x0A & AUTO_CR: BUS_DATA=0x0D, set
//             pending_lf. Else BUS_DATA=b. Drive BUS_CE=0, BUS_RW=0 -> STROBE.
//     STROBE: exactly one BUS_CLK period with CE=0,RW=0. Next tick: CE=1, RW=1, load gap
//             counter = GAP_CYCLES-1 -> GAP. (BUS_DATA holds its value.)
//     GAP:    counter down to 0; then: pending_lf -> clear it, BUS_DATA=0x0A, CE=0, RW=0 ->
//             STROBE; else if last strobed byte==0x7F -> load CLEAR_WAIT-1 -> HOLD;
//             else -> IDLE (may issue next strobe on the following tick).
//     HOLD:   CE=1; counter down to 0 -> IDLE.
//   Counters sized $clog2(max(GAP_CYCLES,CLEAR_WAIT))+1; no wrap. Minimum spacing between
//     strobe starts: 1+GAP_CYCLES BUS_CLK periods (+CLEAR_WAIT after 0x7F).
//   All bytes 0x00-0xFF are passed through unmodified except 0x0A expansion; no rate limit on
//     0x0D/0x0A beyond GAP. BUS_RW never 0 while BUS_CE=1.
//   BUSY = (count!=0) | (state!=IDLE) | pending_lf.
// TESTING
//   1 Push 0x41 after reset, CLK_DIV=2 -> one BUS_CLK period CE=0,RW=0,DATA=0x41 spanning a
//     falling edge; then CE=1 for >=1 period; BUSY falls after GAP.
//   2 Push 0x0A, AUTO_CR=1 -> strobes 0x0D then 0x0A, each 1 period, separated by GAP; with
//     AUTO_CR=0 -> single strobe 0x0A.
//   3 Push 0x7F, 0x42 -> 0x42 strobe starts exactly 1+GAP_CYCLES+CLEAR_WAIT BUS_CLK periods
//     after 0x7F strobe start.
//   4 Hold CHAR_VALID high with 20 bytes, FIFO_DEPTH=16 -> CHAR_READY drops after 16 accepted
//     (none popped yet), all 20 appear on bus in order, none dropped or duplicated.
//   5 Assert RST during STROBE of 0x55 -> CE=1, RW=1, DATA=0 same cycle; after release
//     FIFO empty, BUSY=0, no strobe issued.
//   6 Behavioural GPU model on bus, print "HI\n" then 0x7F -> model framebuffer matches and
//     is cleared; no write lands during model's CLEARING state.

Source files
------------

// File: rtl/gpu_text_writer_if.sv
// gpu_text_writer_if: character stream in, GPU write bus out
interface gpu_text_writer_if;
  logic [7:0] CHAR_DATA;
  logic       CHAR_VALID;
  logic       CHAR_READY;
  logic       BUSY;
  logic       BUS_CLK;
  logic       BUS_CE;
  logic       BUS_RW;
  logic [7:0] BUS_DATA;
  modport master (
    input  CHAR_DATA, CHAR_VALID,
    output CHAR_READY, BUSY, BUS_CLK, BUS_CE, BUS_RW, BUS_DATA
  );
  modport slave (
    output CHAR_DATA, CHAR_VALID,
    input  CHAR_READY, BUSY, BUS_CLK, BUS_CE, BUS_RW, BUS_DATA
  );
endinterface

// File: rtl/gpu_text_writer.sv
// gpu_text_writer: FIFO-buffered byte stream to text-mode GPU write strobes with generated bus clock
module gpu_text_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 1,
  parameter int CLEAR_WAIT = 4803,
  parameter bit AUTO_CR    = 1'b1
) (
  input logic CLK_SYS,
  input logic RST,
  gpu_text_writer_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int CW = $clog2(GAP_CYCLES > CLEAR_WAIT ? GAP_CYCLES : CLEAR_WAIT) + 1;
  typedef enum logic [1:0] {IDLE, STROBE, GAP, HOLD} state_t;
  state_t        state;
  logic [DW-1:0] div;
  logic          bclk, ce, rw, rdy, pend;
  logic [7:0]    dat;
  logic [CW-1:0] cnt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count, count_nxt;
  logic          tick, push, pop, free;
  logic [7:0]    head;
  assign tick      = !bclk && div == DW'(CLK_DIV - 1);
  // a finished GAP/HOLD launches the next byte on the same tick so strobe spacing is exactly 1+GAP
  assign free      = state == IDLE || (cnt == '0 && (state == HOLD || (state == GAP && !pend && dat != 8'h7F)));
  assign push      = bus.CHAR_VALID && rdy;
  assign pop       = tick && free && count != '0;
  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
  assign head      = mem[rp];
  always_ff @(posedge CLK_SYS or posedge RST)
    if (RST) begin
      div  <= '0;
      bclk <= 1'b0;
    end else if (div == DW'(CLK_DIV - 1)) begin
      div  <= '0;
      bclk <= ~bclk;
    end else begin
      div  <= div + 1'b1;
    end
  always_ff @(posedge CLK_SYS)
    if (push) mem[wp] <= bus.CHAR_DATA;
  always_ff @(posedge CLK_SYS or posedge RST)
    if (RST) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      rdy   <= 1'b0;
    end else begin
      wp    <= wp + AW'(push);
      rp    <= rp + AW'(pop);
      count <= count_nxt;
      rdy   <= count_nxt != (AW+1)'(FIFO_DEPTH);
    end
  always_ff @(posedge CLK_SYS or posedge RST)
    if (RST) begin
      state <= IDLE;
      ce    <= 1'b1;
      rw    <= 1'b1;
      dat   <= '0;
      cnt   <= '0;
      pend  <= 1'b0;
    end else if (tick) begin
      if (state == GAP && cnt == '0 && pend) begin
        pend  <= 1'b0;
        dat   <= 8'h0A;
        ce    <= 1'b0;
        rw    <= 1'b0;
        state <= STROBE;
      end else if (state == STROBE) begin
        ce    <= 1'b1;
        rw    <= 1'b1;
        cnt   <= CW'(GAP_CYCLES - 1);
        state <= GAP;
      end else if ((state == GAP || state == HOLD) && cnt != '0) begin
        cnt   <= cnt - 1'b1;
      end else if (state == GAP && dat == 8'h7F) begin
        cnt   <= CW'(CLEAR_WAIT - 1);
        state <= HOLD;
      end else if (pop) begin
        dat   <= (AUTO_CR && head == 8'h0A) ? 8'h0D : head;
        pend  <= AUTO_CR && head == 8'h0A;
        ce    <= 1'b0;
        rw    <= 1'b0;
        state <= STROBE;
      end else begin
        state <= IDLE;
      end
    end
  assign bus.CHAR_READY = rdy;
  assign bus.BUSY       = count != '0 || state != IDLE || pend;
  assign bus.BUS_CLK    = bclk;
  assign bus.BUS_CE     = ce;
  assign bus.BUS_RW     = rw;
  assign bus.BUS_DATA   = dat;
endmodule

// File: tb/tb_gpu_text_writer.sv
// tb_gpu_text_writer: scoreboard bench with a small GPU framebuffer model on the write bus
module tb_gpu_text_writer;
  localparam int CWA = 40;
  localparam int GAP = 1;
  logic CLK_SYS = 1'b0;
  logic RST = 1'b1;
  always #5 CLK_SYS = ~CLK_SYS;
  gpu_text_writer_if ia();
  gpu_text_writer_if ib();
  gpu_text_writer #(.FIFO_DEPTH(16), .CLK_DIV(2), .GAP_CYCLES(GAP), .CLEAR_WAIT(CWA), .AUTO_CR(1'b1))
    dut_a (.CLK_SYS(CLK_SYS), .RST(RST), .bus(ia));
  gpu_text_writer #(.FIFO_DEPTH(16), .CLK_DIV(2), .GAP_CYCLES(GAP), .CLEAR_WAIT(8), .AUTO_CR(1'b0))
    dut_b (.CLK_SYS(CLK_SYS), .RST(RST), .bus(ib));
  int compared = 0;
  int mismatched = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic pa = 1'b0, pb = 1'b0;
  int fe = 0, last_fe = 0, row = 0, col = 0;
  logic [7:0] last = 8'h00;
  logic [7:0] fb [4][16];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic strobe_a(input logic [7:0] d);
    check("a_sb_nonempty", 32'(qa.size() != 0), 1);
    if (qa.size() != 0) check("a_data", 32'(d), 32'(qa.pop_front()));
    if (last == 8'h7F) check("clear_spacing", fe - last_fe, 1 + GAP + CWA);
    if (last == 8'h0D && d == 8'h0A) check("crlf_spacing", fe - last_fe, 1 + GAP);
    if (d == 8'h7F) begin
      for (int r = 0; r < 4; r++) for (int c = 0; c < 16; c++) fb[r][c] = 8'h00;
      row = 0;
      col = 0;
    end else if (d == 8'h0D) col = 0;
    else if (d == 8'h0A) row = (row + 1) % 4;
    else begin
      fb[row][col] = d;
      col = (col + 1) % 16;
    end
    last = d;
    last_fe = fe;
  endtask
  // strobes are taken at each BUS_CLK falling edge, the point where the GPU samples the bus
  always @(negedge CLK_SYS) begin
    if (pa && !ia.BUS_CLK) begin
      fe++;
      check("a_rw_ce", 32'(ia.BUS_RW), 32'(ia.BUS_CE));
      if (!ia.BUS_CE) strobe_a(ia.BUS_DATA);
    end
    pa = ia.BUS_CLK;
    if (pb && !ib.BUS_CLK) begin
      check("b_rw_ce", 32'(ib.BUS_RW), 32'(ib.BUS_CE));
      if (!ib.BUS_CE) begin
        check("b_sb_nonempty", 32'(qb.size() != 0), 1);
        if (qb.size() != 0) check("b_data", 32'(ib.BUS_DATA), 32'(qb.pop_front()));
      end
    end
    pb = ib.BUS_CLK;
  end
  task automatic push(input bit sel, input logic [7:0] b);
    logic ok = 1'b0;
    int n = 0;
    if (sel) begin ib.CHAR_DATA = b; ib.CHAR_VALID = 1'b1; end
    else begin ia.CHAR_DATA = b; ia.CHAR_VALID = 1'b1; end
    while (!ok && n < 5000) begin
      ok = sel ? ib.CHAR_READY : ia.CHAR_READY;
      @(negedge CLK_SYS);
      n++;
    end
    ia.CHAR_VALID = 1'b0;
    ib.CHAR_VALID = 1'b0;
    check("push_accept", 32'(ok), 1);
    if (ok) begin
      if (sel) qb.push_back(b);
      else if (b == 8'h0A) begin qa.push_back(8'h0D); qa.push_back(8'h0A); end
      else qa.push_back(b);
    end
  endtask
  task automatic drain(input string tag);
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || ia.BUSY || ib.BUSY) && n < 30000) begin
      @(negedge CLK_SYS);
      n++;
    end
    check({tag, "_busy"}, 32'(ia.BUSY | ib.BUSY), 0);
    check({tag, "_left"}, qa.size() + qb.size(), 0);
  endtask
  initial begin
    int n, nz;
    bit full_seen;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 16; c++) fb[r][c] = 8'h00;
    ia.CHAR_DATA = 8'h00; ia.CHAR_VALID = 1'b0;
    ib.CHAR_DATA = 8'h00; ib.CHAR_VALID = 1'b0;
    repeat (3) @(negedge CLK_SYS);
    check("rst_clk", 32'(ia.BUS_CLK), 0);
    check("rst_ce", 32'(ia.BUS_CE), 1);
    check("rst_rw", 32'(ia.BUS_RW), 1);
    check("rst_data", 32'(ia.BUS_DATA), 0);
    check("rst_ready", 32'(ia.CHAR_READY), 0);
    check("rst_busy", 32'(ia.BUSY), 0);
    RST = 1'b0;
    repeat (3) @(negedge CLK_SYS);
    check("ready_after_rst", 32'(ia.CHAR_READY), 1);
    push(0, 8'h41);
    check("busy_after_push", 32'(ia.BUSY), 1);
    drain("t1");
    push(0, 8'h0A);
    push(1, 8'h0A);
    drain("t2");
    push(0, 8'h7F);
    push(0, 8'h42);
    drain("t3");
    push(0, 8'h7F);
    repeat (20) @(negedge CLK_SYS);
    full_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!ia.CHAR_READY && !full_seen) begin
        check("fifo_fill", i, 16);
        full_seen = 1'b1;
      end
      push(0, 8'h30 + 8'(i));
    end
    check("fifo_full_seen", 32'(full_seen), 1);
    drain("t4");
    push(0, 8'h55);
    n = 0;
    while (ia.BUS_CE && n < 200) begin @(negedge CLK_SYS); n++; end
    check("t5_strobe_seen", 32'(ia.BUS_CE), 0);
    check("t5_strobe_data", 32'(ia.BUS_DATA), 32'h55);
    RST = 1'b1;
    #1;
    check("t5_ce", 32'(ia.BUS_CE), 1);
    check("t5_rw", 32'(ia.BUS_RW), 1);
    check("t5_data", 32'(ia.BUS_DATA), 0);
    qa.delete();
    last = 8'h00;
    repeat (2) @(negedge CLK_SYS);
    RST = 1'b0;
    repeat (60) @(negedge CLK_SYS);
    check("t5_busy", 32'(ia.BUSY), 0);
    check("t5_ready", 32'(ia.CHAR_READY), 1);
    push(0, 8'h7F);
    push(0, "H");
    push(0, "I");
    push(0, 8'h0A);
    drain("t6a");
    check("fb_h", 32'(fb[0][0]), 32'h48);
    check("fb_i", 32'(fb[0][1]), 32'h49);
    check("fb_row", row, 1);
    check("fb_col", col, 0);
    push(0, 8'h7F);
    drain("t6b");
    nz = 0;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 16; c++) if (fb[r][c] != 8'h00) nz++;
    check("fb_cleared", nz, 0);
    check("fb_home", row + col, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
